// File: rtl/xphy_link_ctrl_if.sv
// Status/control bundle between the SFP+ link sequencer (master) and the PCS/PMA + SFP side (slave).
// Status inputs may be asynchronous to clk_156; the sequencer synchronizes them internally.
interface xphy_link_ctrl_if;
    logic        tx_enable;
    logic        gt_resetdone;
    logic        block_lock;
    logic        pcs_status;
    logic        pcs_reset;
    logic        sfp_tx_disable;
    logic        link_up;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] drop_cnt;

    modport master (
        input  tx_enable, gt_resetdone, block_lock, pcs_status,
        output pcs_reset, sfp_tx_disable, link_up, state, retry_cnt, drop_cnt
    );

    modport slave (
        output tx_enable, gt_resetdone, block_lock, pcs_status,
        input  pcs_reset, sfp_tx_disable, link_up, state, retry_cnt, drop_cnt
    );
endinterface

// File: rtl/xphy_link_ctrl.sv
// 10GBASE-R bring-up/supervision FSM: PCS reset, SFP TX disable, lock qualification, retry/backoff.
// Latency: registered outputs track the state register; status inputs add 2 cycles of sync delay.
// No backpressure: level-driven control; tx_enable=0 forces DISABLED on the next edge.
module xphy_link_ctrl #(
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 156250,
    parameter int STABLE_CYCLES  = 1024,
    parameter int BACKOFF_CYCLES = 15625,
    parameter int TIMER_W        = 24
) (
    input  logic              clk_156,
    input  logic              sys_rst,
    xphy_link_ctrl_if.master  phy
);

    localparam logic [2:0] S_DISABLED  = 3'd0;
    localparam logic [2:0] S_RESET     = 3'd1;
    localparam logic [2:0] S_WAIT_GT   = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_STABLE    = 3'd4;
    localparam logic [2:0] S_UP        = 3'd5;
    localparam logic [2:0] S_BACKOFF   = 3'd6;

    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BACKOFF_LAST = TIMER_W'(BACKOFF_CYCLES - 1);

    logic [1:0]         gt_sync_q, bl_sync_q, ps_sync_q;
    logic               gt_resetdone_s, lock_s;

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         retry_q, retry_d;
    logic [15:0]        drop_q, drop_d;
    logic               pcs_reset_q, pcs_reset_d;
    logic               tx_dis_q, tx_dis_d;
    logic               link_up_q, link_up_d;

    always_ff @(posedge clk_156 or posedge sys_rst) begin
        if (sys_rst) begin
            gt_sync_q <= '0;
            bl_sync_q <= '0;
            ps_sync_q <= '0;
        end else begin
            gt_sync_q <= {gt_sync_q[0], phy.gt_resetdone};
            bl_sync_q <= {bl_sync_q[0], phy.block_lock};
            ps_sync_q <= {ps_sync_q[0], phy.pcs_status};
        end
    end

    assign gt_resetdone_s = gt_sync_q[1];
    assign lock_s         = bl_sync_q[1] & ps_sync_q[1];

    always_ff @(posedge clk_156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_DISABLED;
            timer_q     <= '0;
            retry_q     <= '0;
            drop_q      <= '0;
            pcs_reset_q <= 1'b1;
            tx_dis_q    <= 1'b1;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            drop_q      <= drop_d;
            pcs_reset_q <= pcs_reset_d;
            tx_dis_q    <= tx_dis_d;
            link_up_q   <= link_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        drop_d  = drop_q;
        if (!phy.tx_enable) begin
            state_d = S_DISABLED;
        end else begin
            // Success is tested before timeout so a late lock still counts.
            case (state_q)
                S_DISABLED:  state_d = S_RESET;
                S_RESET:     if (timer_q == RESET_LAST) state_d = S_WAIT_GT;
                S_WAIT_GT: begin
                    if (gt_resetdone_s)              state_d = S_WAIT_LOCK;
                    else if (timer_q == LOCK_LAST)   state_d = S_BACKOFF;
                end
                S_WAIT_LOCK: begin
                    if (lock_s)                      state_d = S_STABLE;
                    else if (timer_q == LOCK_LAST)   state_d = S_BACKOFF;
                end
                S_STABLE: begin
                    if (!lock_s)                     state_d = S_WAIT_LOCK;
                    else if (timer_q == STABLE_LAST) state_d = S_UP;
                end
                S_UP: begin
                    if (!lock_s || !gt_resetdone_s) begin
                        state_d = S_BACKOFF;
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end
                end
                S_BACKOFF:   if (timer_q == BACKOFF_LAST) state_d = S_RESET;
                default:     state_d = S_DISABLED;
            endcase

            if (state_d == S_BACKOFF && state_q != S_BACKOFF && retry_q != 4'hF)
                retry_d = retry_q + 4'd1;
            if (state_d == S_UP && state_q != S_UP)
                retry_d = '0;
        end

        if (!phy.tx_enable || state_d != state_q) timer_d = '0;
        else                                      timer_d = timer_q + TIMER_W'(1);
    end

    // Outputs decode the next state so the registered copies line up with state_q.
    always_comb begin
        pcs_reset_d = 1'b1;
        tx_dis_d    = 1'b1;
        link_up_d   = 1'b0;
        case (state_d)
            S_RESET, S_BACKOFF: begin
                pcs_reset_d = 1'b1;
                tx_dis_d    = 1'b0;
            end
            S_WAIT_GT, S_WAIT_LOCK, S_STABLE: begin
                pcs_reset_d = 1'b0;
                tx_dis_d    = 1'b0;
            end
            S_UP: begin
                pcs_reset_d = 1'b0;
                tx_dis_d    = 1'b0;
                link_up_d   = 1'b1;
            end
            default: begin
                pcs_reset_d = 1'b1;
                tx_dis_d    = 1'b1;
                link_up_d   = 1'b0;
            end
        endcase
    end

    assign phy.pcs_reset      = pcs_reset_q;
    assign phy.sfp_tx_disable = tx_dis_q;
    assign phy.link_up        = link_up_q;
    assign phy.state          = state_q;
    assign phy.retry_cnt      = retry_q;
    assign phy.drop_cnt       = drop_q;

endmodule

// File: tb/tb_xphy_link_ctrl.sv
// Directed bench for xphy_link_ctrl with short timing parameters; expectations queued then popped.
module tb_xphy_link_ctrl;

    logic clk;
    logic rst;

    xphy_link_ctrl_if phy ();

    xphy_link_ctrl #(
        .RESET_CYCLES   (4),
        .LOCK_TIMEOUT   (64),
        .STABLE_CYCLES  (8),
        .BACKOFF_CYCLES (16),
        .TIMER_W        (24)
    ) dut (
        .clk_156 (clk),
        .sys_rst (rst),
        .phy     (phy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    // Advance n edges, then compare the state encoding.
    task automatic st(input string tag, input int n, input logic [2:0] s);
        sb_push(32'(s));
        tick(n);
        chk(tag, 32'(phy.state));
    endtask

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] e);
        sb_push(e);
        chk(tag, obs);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s, input logic pr, input logic td,
                           input logic lu, input logic [3:0] rc, input logic [15:0] dc);
        sb_push(32'(s));  sb_push(32'(pr)); sb_push(32'(td));
        sb_push(32'(lu)); sb_push(32'(rc)); sb_push(32'(dc));
        chk({tag, "_state"},   32'(phy.state));
        chk({tag, "_pcs_rst"}, 32'(phy.pcs_reset));
        chk({tag, "_tx_dis"},  32'(phy.sfp_tx_disable));
        chk({tag, "_link_up"}, 32'(phy.link_up));
        chk({tag, "_retry"},   32'(phy.retry_cnt));
        chk({tag, "_drop"},    32'(phy.drop_cnt));
    endtask

    initial begin
        rst              = 1'b1;
        phy.tx_enable    = 1'b0;
        phy.gt_resetdone = 1'b1;
        phy.block_lock   = 1'b1;
        phy.pcs_status   = 1'b1;
        tick(100);
        chk_all("rst", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0);

        // Nominal bring-up
        rst           = 1'b0;
        phy.tx_enable = 1'b1;
        st("t1_reset", 1, 3'd1);
        chk1("t1_reset_pcs", 32'(phy.pcs_reset), 1);
        chk1("t1_reset_txdis", 32'(phy.sfp_tx_disable), 0);
        st("t1_reset_hold", 3, 3'd1);
        chk1("t1_reset_hold_pcs", 32'(phy.pcs_reset), 1);
        st("t1_wait_gt", 1, 3'd2);
        chk1("t1_wait_gt_pcs", 32'(phy.pcs_reset), 0);
        st("t1_wait_lock", 1, 3'd3);
        st("t1_stable", 1, 3'd4);
        st("t1_stable_hold", 7, 3'd4);
        chk1("t1_pre_up_link", 32'(phy.link_up), 0);
        st("t1_up", 1, 3'd5);
        chk_all("t1_up", 3'd5, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0);

        // Link loss from UP
        phy.block_lock = 1'b0;
        st("t4_sync_delay", 2, 3'd5);
        chk1("t4_sync_link", 32'(phy.link_up), 1);
        st("t4_backoff", 1, 3'd6);
        chk_all("t4_backoff", 3'd6, 1'b1, 1'b0, 1'b0, 4'd1, 16'd1);
        phy.block_lock = 1'b1;
        st("t4_backoff_hold", 15, 3'd6);
        chk1("t4_backoff_pcs", 32'(phy.pcs_reset), 1);
        st("t4_reset", 1, 3'd1);
        st("t4_wait_gt", 4, 3'd2);
        st("t4_wait_lock", 1, 3'd3);
        st("t4_stable", 1, 3'd4);
        tick(5);

        // One-cycle lock glitch at STABLE timer=5
        phy.block_lock = 1'b0;
        st("t3_glitch_a", 1, 3'd4);
        phy.block_lock = 1'b1;
        st("t3_glitch_b", 1, 3'd4);
        st("t3_back_wait_lock", 1, 3'd3);
        chk1("t3_retry_kept", 32'(phy.retry_cnt), 1);
        st("t3_restable", 1, 3'd4);
        st("t3_restable_hold", 7, 3'd4);
        st("t3_up", 1, 3'd5);
        chk_all("t3_up", 3'd5, 1'b0, 1'b0, 1'b1, 4'd0, 16'd1);

        // Disable override from UP, then from WAIT_LOCK
        phy.tx_enable = 1'b0;
        st("t5_up_dis", 1, 3'd0);
        chk_all("t5_up_dis", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd1);
        phy.tx_enable  = 1'b1;
        phy.block_lock = 1'b0;
        st("t5_reset", 1, 3'd1);
        st("t5_wait_gt", 4, 3'd2);
        st("t5_wait_lock", 1, 3'd3);
        st("t5_wait_lock_hold", 3, 3'd3);
        phy.tx_enable = 1'b0;
        st("t5_wl_dis", 1, 3'd0);
        chk_all("t5_wl_dis", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd1);

        // No GT reset-done: repeated timeouts
        phy.gt_resetdone = 1'b0;
        phy.block_lock   = 1'b1;
        tick(3);
        phy.tx_enable = 1'b1;
        st("t2_reset", 1, 3'd1);
        st("t2_wait_gt", 4, 3'd2);
        st("t2_wait_gt_hold", 63, 3'd2);
        st("t2_backoff1", 1, 3'd6);
        chk1("t2_retry1", 32'(phy.retry_cnt), 1);
        st("t2_backoff1_hold", 15, 3'd6);
        st("t2_reset1", 1, 3'd1);
        for (int k = 2; k <= 3; k++) begin
            st("t2_wait_gt_k", 4, 3'd2);
            st("t2_backoff_k", 64, 3'd6);
            chk1("t2_retry_k", 32'(phy.retry_cnt), 32'(k));
            st("t2_reset_k", 16, 3'd1);
        end

        // Saturation, then async reset mid-BACKOFF
        for (int k = 4; k <= 20; k++) begin
            st("t6_backoff_k", 68, 3'd6);
            chk1("t6_retry_k", 32'(phy.retry_cnt), (k > 15) ? 32'd15 : 32'(k));
            if (k < 20) st("t6_reset_k", 16, 3'd1);
        end
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        chk_all("t6_async_rst", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
        tick(2);

        // Success beats timeout on the same cycle
        rst = 1'b0;
        st("tie_reset", 1, 3'd1);
        st("tie_wait_gt", 4, 3'd2);
        tick(61);
        phy.gt_resetdone = 1'b1;
        st("tie_wait_gt_last", 2, 3'd2);
        st("tie_wait_lock", 1, 3'd3);
        chk1("tie_retry", 32'(phy.retry_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
